// File: rtl/chip8_fetch_unit_if.sv
// Fetch-unit bus: program-memory read port plus the opcode handshake
// toward the decoder and the control-flow command coming back from it.
interface chip8_fetch_unit_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_data;
    logic              op_valid;
    logic              op_ready;
    logic [15:0]       opcode;
    logic [ADDR_W-1:0] op_pc;
    logic [2:0]        cmd;
    logic [ADDR_W-1:0] target;

    // Fetch unit side.
    modport master (
        output mem_addr, mem_rd, op_valid, opcode, op_pc,
        input  mem_data, op_ready, cmd, target
    );

    // Memory/decoder side.
    modport slave (
        input  mem_addr, mem_rd, op_valid, opcode, op_pc,
        output mem_data, op_ready, cmd, target
    );
endinterface

// File: rtl/chip8_fetch_unit.sv
// CHIP-8 instruction fetch and control-flow unit.
// Fetches a big-endian 16-bit opcode as two byte reads, hands it to the
// decoder over valid/ready, then applies NEXT/JUMP/CALL/RET/SKIP using a
// small return stack. Stack overflow/underflow parks the unit in FAULT.
module chip8_fetch_unit #(
    parameter int                ADDR_W      = 12,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(12'h200),
    parameter int                STACK_DEPTH = 16,
    parameter int                MEM_LATENCY = 1,
    localparam int               SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    chip8_fetch_unit_if.master  bus,
    output logic [SP_W-1:0]     sp,
    output logic                fault
);

    localparam int              IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [2:0]      LAT     = 3'(MEM_LATENCY);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0] SP_ZERO = {SP_W{1'b0}};

    localparam logic [2:0] CMD_JUMP = 3'd1;
    localparam logic [2:0] CMD_CALL = 3'd2;
    localparam logic [2:0] CMD_RET  = 3'd3;
    localparam logic [2:0] CMD_SKIP = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_HI   = 3'd1,
        S_WAIT_HI = 3'd2,
        S_RD_LO   = 3'd3,
        S_WAIT_LO = 3'd4,
        S_VALID   = 3'd5,
        S_FAULT   = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [SP_W-1:0]   r_sp;
    logic              r_fault;
    logic [2:0]        r_cnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic              r_op_valid;
    logic [15:0]       r_opcode;
    logic [ADDR_W-1:0] r_op_pc;
    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

    logic              w_hs;
    logic              w_call;
    logic              w_ret;
    logic              w_ovf;
    logic              w_unf;
    logic [SP_W-1:0]   w_sp_dec;
    logic [IDX_W-1:0]  w_push_idx;
    logic [IDX_W-1:0]  w_pop_idx;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_skip;

    // op_valid is high exactly while in VALID, so the state alone qualifies the handshake.
    assign w_hs       = (r_state == S_VALID) && bus.op_ready;
    assign w_call     = (bus.cmd == CMD_CALL);
    assign w_ret      = (bus.cmd == CMD_RET);
    assign w_ovf      = w_call && (r_sp == SP_FULL);
    assign w_unf      = w_ret && (r_sp == SP_ZERO);
    assign w_sp_dec   = r_sp - SP_W'(1);
    assign w_push_idx = r_sp[IDX_W-1:0];
    assign w_pop_idx  = w_sp_dec[IDX_W-1:0];
    assign w_pc_inc   = r_pc + ADDR_W'(1);
    assign w_pc_skip  = r_pc + ADDR_W'(2);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the wait states end on the cycle the counter hits zero.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (tick) w_state_nxt = S_RD_HI;
                else      w_state_nxt = S_IDLE;
            end
            S_RD_HI:   w_state_nxt = S_WAIT_HI;
            S_WAIT_HI: begin
                if (r_cnt == 3'd1) w_state_nxt = S_RD_LO;
                else               w_state_nxt = S_WAIT_HI;
            end
            S_RD_LO:   w_state_nxt = S_WAIT_LO;
            S_WAIT_LO: begin
                if (r_cnt == 3'd1) w_state_nxt = S_VALID;
                else               w_state_nxt = S_WAIT_LO;
            end
            S_VALID: begin
                if (w_hs) begin
                    if (w_ovf || w_unf) w_state_nxt = S_FAULT;
                    else                w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_VALID;
                end
            end
            S_FAULT:   w_state_nxt = S_FAULT;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: byte reads, opcode capture, PC/stack-pointer update on handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_sp       <= SP_ZERO;
            r_fault    <= 1'b0;
            r_cnt      <= 3'd0;
            r_mem_addr <= {ADDR_W{1'b0}};
            r_mem_rd   <= 1'b0;
            r_op_valid <= 1'b0;
            r_opcode   <= 16'h0000;
            r_op_pc    <= {ADDR_W{1'b0}};
        end else begin
            r_mem_rd <= 1'b0;
            case (r_state)
                S_RD_HI, S_RD_LO: begin
                    r_mem_addr <= r_pc;
                    r_mem_rd   <= 1'b1;
                    r_pc       <= w_pc_inc;
                    r_cnt      <= LAT;
                    if (r_state == S_RD_HI) r_op_pc <= r_pc;
                end
                S_WAIT_HI: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) r_opcode[15:8] <= bus.mem_data;
                end
                S_WAIT_LO: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_opcode[7:0] <= bus.mem_data;
                        r_op_valid    <= 1'b1;
                    end
                end
                S_VALID: begin
                    if (w_hs) begin
                        r_op_valid <= 1'b0;
                        // PC already points past the opcode (op_pc+2) here.
                        case (bus.cmd)
                            CMD_JUMP: r_pc <= bus.target;
                            CMD_SKIP: r_pc <= w_pc_skip;
                            CMD_CALL: begin
                                if (w_ovf) begin
                                    r_fault <= 1'b1;
                                end else begin
                                    r_sp <= r_sp + SP_W'(1);
                                    r_pc <= bus.target;
                                end
                            end
                            CMD_RET: begin
                                if (w_unf) begin
                                    r_fault <= 1'b1;
                                end else begin
                                    r_sp <= w_sp_dec;
                                    r_pc <= r_stack[w_pop_idx];
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // Return-stack storage; entries at or above sp are dead, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_hs && w_call && !w_ovf) r_stack[w_push_idx] <= r_pc;
    end

    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_rd   = r_mem_rd;
    assign bus.op_valid = r_op_valid;
    assign bus.opcode   = r_opcode;
    assign bus.op_pc    = r_op_pc;
    assign sp           = r_sp;
    assign fault        = r_fault;

endmodule
